// File: rtl/vec_sub_pkg.sv
// Shared definitions for the lane-serialised vector subtractor:
// FSM encoding, beat-counter sizing and element slicing helpers.
package vec_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A single-beat configuration still needs a 1-bit counter to keep ports legal.
    function automatic int beat_cnt_w(input int wc, input int p);
        int nb;
        nb = wc / p;
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

    function automatic int elem_lsb(input int w, input int k);
        return w * k;
    endfunction

endpackage

// File: rtl/lane_sub_sat.sv
// One subtract lane: W-bit signed a - b with optional saturation and an
// overflow flag taken from the (W+1)-bit true difference.
module lane_sub_sat #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sat,
    output logic [W-1:0] res,
    output logic         ovf
);

    logic [W:0] d_wide;

    always_comb begin
        d_wide = {a[W-1], a} - {b[W-1], b};
        ovf    = d_wide[W] ^ d_wide[W-1];
        res    = d_wide[W-1:0];
        if (ovf && sat) begin
            res = d_wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/vec_sub_seq.sv
// Element-wise L - E over WC elements using P shared lanes across WC/P beats,
// with valid/ready on both sides and a DONE->RUN handoff for full throughput.
//
// state   | meaning
// IDLE    | waiting for a vector, in_ready=1
// RUN     | one beat of P elements per cycle into the internal result
// DONE    | result presented on diff/ovf until out_ready
module vec_sub_seq
    import vec_sub_pkg::*;
#(
    parameter int W  = 6,
    parameter int WC = 32,
    parameter int P  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W*WC-1:0] L,
    input  logic [W*WC-1:0] E,
    input  logic            sat,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W*WC-1:0] diff,
    output logic [WC-1:0]   ovf
);

    localparam int NB = WC / P;
    localparam int BW = beat_cnt_w(WC, P);

    generate
        if (W < 2 || P < 1 || P > WC || (WC % P) != 0) begin : g_bad_cfg
            $error("vec_sub_seq: illegal W/WC/P combination");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [W*WC-1:0]   l_q, l_d, e_q, e_d;
    logic              sat_q, sat_d;
    logic [W*WC-1:0]   res_q, res_d;
    logic [WC-1:0]     rovf_q, rovf_d;
    logic [W*WC-1:0]   diff_q, diff_d;
    logic [WC-1:0]     ovf_q, ovf_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic              last_beat;
    int                base;
    logic [W*P-1:0]    lane_a, lane_b, lane_r;
    logic [P-1:0]      lane_ovf;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last_beat) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin : p_outputs
        in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
        out_valid = out_valid_q;
        diff      = diff_q;
        ovf       = ovf_q;
    end

    assign accept    = in_valid && in_ready;
    assign last_beat = (state_q == ST_RUN) && (beat_q == BW'(NB - 1));

    always_comb begin : p_lane_mux
        base   = int'(beat_q) * P;
        lane_a = '0;
        lane_b = '0;
        for (int j = 0; j < P; j++) begin
            lane_a[j*W +: W] = l_q[elem_lsb(W, base + j) +: W];
            lane_b[j*W +: W] = e_q[elem_lsb(W, base + j) +: W];
        end
    end

    for (genvar j = 0; j < P; j++) begin : g_lane
        lane_sub_sat #(.W(W)) u_lane (
            .a   (lane_a[j*W +: W]),
            .b   (lane_b[j*W +: W]),
            .sat (sat_q),
            .res (lane_r[j*W +: W]),
            .ovf (lane_ovf[j])
        );
    end

    always_comb begin : p_datapath
        beat_d      = beat_q;
        l_d         = l_q;
        e_d         = e_q;
        sat_d       = sat_q;
        res_d       = res_q;
        rovf_d      = rovf_q;
        diff_d      = diff_q;
        ovf_d       = ovf_q;
        if (state_q == ST_RUN) begin
            for (int j = 0; j < P; j++) begin
                res_d[elem_lsb(W, base + j) +: W] = lane_r[j*W +: W];
                rovf_d[base + j]                  = lane_ovf[j];
            end
            beat_d = last_beat ? '0 : beat_q + BW'(1);
            // The final beat's lanes must be included in the delivered vector.
            if (last_beat) begin
                diff_d = res_d;
                ovf_d  = rovf_d;
            end
        end
        if (accept) begin
            l_d    = L;
            e_d    = E;
            sat_d  = sat;
            beat_d = '0;
        end
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q      <= '0;
            l_q         <= '0;
            e_q         <= '0;
            sat_q       <= 1'b0;
            res_q       <= '0;
            rovf_q      <= '0;
            diff_q      <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            l_q         <= l_d;
            e_q         <= e_d;
            sat_q       <= sat_d;
            res_q       <= res_d;
            rovf_q      <= rovf_d;
            diff_q      <= diff_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_vec_sub_seq.sv
// Directed bench for vec_sub_seq: default P=8 instance plus P=1 and P=32
// instances checked against an integer reference model.
module tb_vec_sub_seq;

    localparam int W  = 6;
    localparam int WC = 32;
    localparam int VW = W * WC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, iv1 = 1'b0, iv32 = 1'b0;
    logic          out_ready = 1'b0;
    logic          sat = 1'b0;
    logic [VW-1:0] L = '0, E = '0;

    logic          in_ready, out_valid;
    logic [VW-1:0] diff;
    logic [WC-1:0] ovf;
    logic          ir1, ov1, ir32, ov32;
    logic [VW-1:0] d1, d32;
    logic [WC-1:0] o1, o32;

    int n_cmp = 0;
    int n_err = 0;

    vec_sub_seq #(.W(W), .WC(WC), .P(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .L(L), .E(E), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .ovf(ovf)
    );

    vec_sub_seq #(.W(W), .WC(WC), .P(1)) dut_p1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .L(L), .E(E), .sat(sat), .out_valid(ov1), .out_ready(out_ready),
        .diff(d1), .ovf(o1)
    );

    vec_sub_seq #(.W(W), .WC(WC), .P(32)) dut_p32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .L(L), .E(E), .sat(sat), .out_valid(ov32), .out_ready(out_ready),
        .diff(d32), .ovf(o32)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic ov_of(input int which);
        case (which)
            1:       return ov1;
            2:       return ov32;
            default: return out_valid;
        endcase
    endfunction

    task automatic send(input int which);
        case (which)
            1:       iv1 = 1'b1;
            2:       iv32 = 1'b1;
            default: in_valid = 1'b1;
        endcase
        step();
        in_valid = 1'b0;
        iv1      = 1'b0;
        iv32     = 1'b0;
    endtask

    task automatic wait_valid(input int which, output int n);
        n = 0;
        while (ov_of(which) !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    function automatic logic [VW-1:0] fill(input int v);
        logic [VW-1:0] f;
        f = '0;
        for (int k = 0; k < WC; k++) f[k*W +: W] = W'(v);
        return f;
    endfunction

    function automatic logic [VW-1:0] put(input logic [VW-1:0] v, input int k, input int x);
        logic [VW-1:0] r;
        r = v;
        r[k*W +: W] = W'(x);
        return r;
    endfunction

    task automatic model(input logic [VW-1:0] l, input logic [VW-1:0] e, input logic s,
                         output logic [VW-1:0] d, output logic [WC-1:0] o);
        logic signed [W-1:0] ta, tb;
        int r;
        d = '0;
        o = '0;
        for (int k = 0; k < WC; k++) begin
            ta = l[k*W +: W];
            tb = e[k*W +: W];
            r = int'(ta) - int'(tb);
            o[k] = (r > 31) || (r < -32);
            if (s && r > 31)  r = 31;
            if (s && r < -32) r = -32;
            d[k*W +: W] = W'(r);
        end
    endtask

    initial begin
        int n;
        int seen;
        logic [VW-1:0] exp_d;
        logic [WC-1:0] exp_o;

        // reset
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_out_valid", VW'(out_valid), VW'(0));
        check("rst_diff", diff, '0);
        check("rst_ovf", VW'(ovf), VW'(0));
        check("rst_in_ready", VW'(in_ready), VW'(1));

        // wrap basic
        L = fill(5); E = fill(3); sat = 1'b0; out_ready = 1'b1;
        send(0);
        check("run_in_ready", VW'(in_ready), VW'(0));
        wait_valid(0, n);
        check("lat_basic", VW'(n), VW'(4));
        check("basic_diff", diff, fill(2));
        check("basic_ovf", VW'(ovf), VW'(0));
        step();
        check("basic_valid_drop", VW'(out_valid), VW'(0));
        check("basic_hold_diff", diff, fill(2));
        check("basic_idle_ready", VW'(in_ready), VW'(1));

        // overflow corners
        L = fill(5); E = fill(3);
        L = put(L, 0, 31);  E = put(E, 0, -1);
        L = put(L, 1, -32); E = put(E, 1, 1);
        L = put(L, 2, -32); E = put(E, 2, -32);
        L = put(L, 3, -1);  E = put(E, 3, 31);
        L = put(L, 4, 30);  E = put(E, 4, -1);
        sat = 1'b1;
        send(0);
        wait_valid(0, n);
        exp_d = fill(2);
        exp_d = put(exp_d, 0, 31);
        exp_d = put(exp_d, 1, -32);
        exp_d = put(exp_d, 2, 0);
        exp_d = put(exp_d, 3, -32);
        exp_d = put(exp_d, 4, 31);
        check("sat_diff", diff, exp_d);
        check("sat_ovf", VW'(ovf), VW'(32'h0000_0003));
        step();
        sat = 1'b0;
        send(0);
        wait_valid(0, n);
        exp_d = put(exp_d, 0, -32);
        exp_d = put(exp_d, 1, 31);
        check("wrap_diff", diff, exp_d);
        check("wrap_ovf", VW'(ovf), VW'(32'h0000_0003));
        step();

        // back-pressure and DONE->RUN handoff
        out_ready = 1'b0;
        L = fill(10); E = fill(-4); sat = 1'b0;
        send(0);
        wait_valid(0, n);
        check("lat_bp", VW'(n), VW'(4));
        L = fill(-20); E = fill(20); sat = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_diff", diff, fill(14));
            check("bp_ovf", VW'(ovf), VW'(0));
            check("bp_in_ready", VW'(in_ready), VW'(0));
            check("bp_out_valid", VW'(out_valid), VW'(1));
        end
        out_ready = 1'b1;
        #1;
        check("handoff_in_ready", VW'(in_ready), VW'(1));
        step();
        in_valid = 1'b0;
        check("handoff_valid_drop", VW'(out_valid), VW'(0));
        check("handoff_hold_diff", diff, fill(14));
        wait_valid(0, n);
        check("lat_handoff", VW'(n), VW'(4));
        check("handoff_diff", diff, fill(-32));
        check("handoff_ovf", VW'(ovf), VW'(32'hFFFF_FFFF));
        step();

        // reset at beat 2
        L = fill(1); E = fill(7); sat = 1'b0;
        send(0);
        step();
        step();
        rst = 1'b1;
        step();
        check("rst_run_idle", VW'(in_ready), VW'(1));
        check("rst_run_valid", VW'(out_valid), VW'(0));
        step();
        rst = 1'b0;
        check("rst_run_diff", diff, '0);
        check("rst_run_ovf", VW'(ovf), VW'(0));
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        check("rst_run_no_valid", VW'(seen), VW'(0));
        L = '0; E = '0;
        send(0);
        wait_valid(0, n);
        check("zero_lat", VW'(n), VW'(4));
        check("zero_diff", diff, '0);
        check("zero_ovf", VW'(ovf), VW'(0));
        step();

        // reset while DONE
        out_ready = 1'b0;
        L = fill(3); E = fill(1);
        send(0);
        wait_valid(0, n);
        check("done_diff", diff, fill(2));
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        check("rst_done_valid", VW'(out_valid), VW'(0));
        check("rst_done_diff", diff, '0);

        // P=1 and P=32 against the model
        for (int t = 0; t < 4; t++) begin
            for (int k = 0; k < WC; k++) begin
                L[k*W +: W] = W'($urandom);
                E[k*W +: W] = W'($urandom);
            end
            sat = t[0];
            model(L, E, sat, exp_d, exp_o);
            send(1);
            wait_valid(1, n);
            check("p1_lat", VW'(n), VW'(32));
            check("p1_diff", d1, exp_d);
            check("p1_ovf", VW'(o1), VW'(exp_o));
            step();
            send(2);
            wait_valid(2, n);
            check("p32_lat", VW'(n), VW'(1));
            check("p32_diff", d32, exp_d);
            check("p32_ovf", VW'(o32), VW'(exp_o));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
